// File: rtl/alu_op2_ror_seq_if.sv
// Operand/result handshake bundle for the sequential rotate-right unit.
// The master issues operands and collects results; the slave is the rotator.
interface alu_op2_ror_seq_if #(
    parameter int unsigned WIDTH = 7,
    parameter int unsigned AMT_W = 3
);
    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] a;
    logic [AMT_W-1:0] n;
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] r;
    logic             busy;

    modport master (
        output in_valid, a, n, out_ready,
        input  in_ready, out_valid, r, busy
    );

    modport slave (
        input  in_valid, a, n, out_ready,
        output in_ready, out_valid, r, busy
    );
endinterface

// File: rtl/alu_op2_ror_seq.sv
// Sequential rotate-right, one bit per clock; inverse of the op2 rotate-left unit.
// All outputs come from registers or are decoded from state alone.
module alu_op2_ror_seq #(
    parameter int unsigned WIDTH = 7,
    parameter int unsigned AMT_W = 3
) (
    input  logic               clk,
    input  logic               rst_n,
    alu_op2_ror_seq_if.slave   bus
);

    typedef enum logic [1:0] {StIdle, StShift, StDone} state_e;

    state_e           r_state;
    state_e           w_state_next;
    logic [WIDTH-1:0] r_data;
    logic [AMT_W-1:0] r_count;
    logic             w_accept;
    logic [AMT_W-1:0] w_n_eff;

    // A single subtract only folds amounts below 2*WIDTH.
    if ((1 << AMT_W) > 2 * WIDTH) begin : g_amt_check
        $error("alu_op2_ror_seq: 2**AMT_W must not exceed 2*WIDTH");
    end

    if (WIDTH >= (1 << AMT_W)) begin : g_no_reduce
        assign w_n_eff = bus.n;
    end else begin : g_reduce
        localparam logic [AMT_W:0] WidthExt = (AMT_W + 1)'(WIDTH);
        logic [AMT_W:0] w_n_ext;
        logic [AMT_W:0] w_n_red;
        assign w_n_ext = {1'b0, bus.n};
        assign w_n_red = (w_n_ext >= WidthExt) ? (w_n_ext - WidthExt) : w_n_ext;
        assign w_n_eff = w_n_red[AMT_W-1:0];
    end

    assign w_accept = bus.in_valid && (r_state == StIdle);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= StIdle;
        end else begin
            r_state <= w_state_next;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_data  <= '0;
            r_count <= '0;
        end else if (w_accept) begin
            r_data  <= bus.a;
            r_count <= w_n_eff;
        end else if (r_state == StShift) begin
            r_data  <= {r_data[0], r_data[WIDTH-1:1]};
            r_count <= r_count - AMT_W'(1);
        end
    end

    always_comb begin
        w_state_next = r_state;
        unique case (r_state)
            StIdle: begin
                if (bus.in_valid) begin
                    w_state_next = (w_n_eff == '0) ? StDone : StShift;
                end
            end
            StShift: begin
                if (r_count == AMT_W'(1)) begin
                    w_state_next = StDone;
                end
            end
            StDone: begin
                if (bus.out_ready) begin
                    w_state_next = StIdle;
                end
            end
            default: w_state_next = StIdle;
        endcase
    end

    always_comb begin
        bus.in_ready  = (r_state == StIdle);
        bus.out_valid = (r_state == StDone);
        bus.busy      = (r_state != StIdle);
        bus.r         = r_data;
    end

endmodule

// File: tb/tb_alu_op2_ror_seq.sv
// Self-checking bench for alu_op2_ror_seq: directed scenarios plus random and
// exhaustive traffic compared against an arithmetic rotate model.
module tb_alu_op2_ror_seq;

    logic clk;
    logic rst_n;
    int   n_pass;
    int   n_chk;

    alu_op2_ror_seq_if #(.WIDTH(7), .AMT_W(3)) bus ();

    alu_op2_ror_seq #(.WIDTH(7), .AMT_W(3)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish (time %0t, required < 2000000)", $time);
        $fatal(1, "watchdog");
    end

    function automatic logic [6:0] ror_ref(input logic [6:0] x, input int amt);
        logic [13:0] d;
        d = {x, x} >> (amt % 7);
        return d[6:0];
    endfunction

    function automatic logic [6:0] rol_ref(input logic [6:0] x, input int amt);
        logic [13:0] d;
        d = {x, x} << (amt % 7);
        return d[13:7];
    endfunction

    // Issues one operand with out_ready high; lat is the edge count from the accept
    // edge to the edge where out_valid is first seen high (0 = timed out).
    task automatic run_op(input logic [6:0] a_v, input logic [2:0] n_v,
                          output logic [6:0] r_v, output int lat);
        @(negedge clk);
        for (int w = 0; w < 20 && !bus.in_ready; w++) @(negedge clk);
        bus.in_valid = 1'b1;
        bus.a        = a_v;
        bus.n        = n_v;
        @(posedge clk);
        #1;
        bus.in_valid = 1'b0;
        bus.a        = 7'($urandom);
        bus.n        = 3'($urandom);
        lat = 0;
        r_v = 'x;
        for (int k = 0; k < 20; k++) begin
            @(negedge clk);
            if (bus.out_valid) begin
                lat = k + 1;
                r_v = bus.r;
                break;
            end
        end
    endtask

    task automatic test_reset;
        rst_n         = 1'b1;
        bus.in_valid  = 1'b0;
        bus.out_ready = 1'b1;
        bus.a         = '0;
        bus.n         = '0;
        #1 rst_n = 1'b0;
        repeat (3) @(negedge clk);
        n_chk++; if (bus.in_ready !== 1'b1) $display("FAIL reset_in_ready got %b want 1", bus.in_ready); else n_pass++;
        n_chk++; if (bus.out_valid !== 1'b0) $display("FAIL reset_out_valid got %b want 0", bus.out_valid); else n_pass++;
        n_chk++; if (bus.busy !== 1'b0) $display("FAIL reset_busy got %b want 0", bus.busy); else n_pass++;
        n_chk++; if (bus.r !== 7'd0) $display("FAIL reset_r got %b want 0000000", bus.r); else n_pass++;
        rst_n = 1'b1;
        @(negedge clk);
        n_chk++; if (bus.in_ready !== 1'b1) $display("FAIL post_reset_in_ready got %b want 1", bus.in_ready); else n_pass++;
    endtask

    task automatic test_single_bit;
        logic [6:0] rv;
        int lat;
        run_op(7'b0000001, 3'd1, rv, lat);
        n_chk++; if (rv !== 7'b1000000) $display("FAIL single_r got %b want 1000000", rv); else n_pass++;
        n_chk++; if (lat != 2) $display("FAIL single_latency got %0d want 2", lat); else n_pass++;
        @(negedge clk);
        n_chk++; if (bus.in_ready !== 1'b1) $display("FAIL single_idle_in_ready got %b want 1", bus.in_ready); else n_pass++;
        n_chk++; if (bus.busy !== 1'b0) $display("FAIL single_idle_busy got %b want 0", bus.busy); else n_pass++;
    endtask

    task automatic test_known;
        logic [6:0] rv;
        int lat;
        run_op(7'b1100101, 3'd3, rv, lat);
        n_chk++; if (rv !== 7'b1011100) $display("FAIL known3_r got %b want 1011100", rv); else n_pass++;
        n_chk++; if (lat != 4) $display("FAIL known3_latency got %0d want 4", lat); else n_pass++;
        run_op(7'b1010011, 3'd6, rv, lat);
        n_chk++; if (rv !== 7'b0100111) $display("FAIL known6_r got %b want 0100111", rv); else n_pass++;
        n_chk++; if (lat != 7) $display("FAIL known6_latency got %0d want 7", lat); else n_pass++;
    endtask

    task automatic test_amount_edges;
        logic [6:0] rv;
        int lat;
        for (int amt = 0; amt <= 7; amt += 7) begin
            run_op(7'b0110110, 3'(amt), rv, lat);
            n_chk++; if (rv !== 7'b0110110) $display("FAIL edge_n%0d_r got %b want 0110110", amt, rv); else n_pass++;
            n_chk++; if (lat != 1) $display("FAIL edge_n%0d_latency got %0d want 1", amt, lat); else n_pass++;
        end
    endtask

    task automatic test_random;
        logic [6:0] av, rv;
        logic [2:0] nv;
        int lat;
        for (int i = 0; i < 40; i++) begin
            av = 7'($urandom);
            nv = 3'($urandom_range(0, 7));
            run_op(av, nv, rv, lat);
            n_chk++; if (rv !== ror_ref(av, int'(nv))) $display("FAIL rand_r a=%b n=%0d got %b want %b", av, nv, rv, ror_ref(av, int'(nv))); else n_pass++;
            n_chk++; if (lat != (int'(nv) % 7) + 1) $display("FAIL rand_latency n=%0d got %0d want %0d", nv, lat, (int'(nv) % 7) + 1); else n_pass++;
        end
    endtask

    task automatic test_backpressure;
        logic [6:0] a1, a2, held;
        bit seen;
        a1 = 7'($urandom);
        a2 = 7'($urandom);
        @(negedge clk);
        for (int w = 0; w < 20 && !bus.in_ready; w++) @(negedge clk);
        bus.out_ready = 1'b0;
        bus.in_valid  = 1'b1;
        bus.a         = a1;
        bus.n         = 3'd2;
        @(posedge clk);
        #1 bus.in_valid = 1'b0;
        seen = 0;
        for (int k = 0; k < 20 && !seen; k++) begin
            @(negedge clk);
            seen = bus.out_valid;
        end
        n_chk++; if (!seen) $display("FAIL bp_first_valid got timeout want out_valid"); else n_pass++;
        n_chk++; if (bus.r !== ror_ref(a1, 2)) $display("FAIL bp_first_r got %b want %b", bus.r, ror_ref(a1, 2)); else n_pass++;
        held = ror_ref(a1, 2);
        bus.in_valid = 1'b1;
        for (int c = 0; c < 5; c++) begin
            bus.a = 7'($urandom);
            bus.n = 3'($urandom);
            @(negedge clk);
            n_chk++; if (bus.r !== held) $display("FAIL bp_hold_r cyc %0d got %b want %b", c, bus.r, held); else n_pass++;
            n_chk++; if (bus.in_ready !== 1'b0) $display("FAIL bp_in_ready cyc %0d got %b want 0", c, bus.in_ready); else n_pass++;
            n_chk++; if (bus.out_valid !== 1'b1) $display("FAIL bp_out_valid cyc %0d got %b want 1", c, bus.out_valid); else n_pass++;
        end
        bus.a         = a2;
        bus.n         = 3'd3;
        bus.out_ready = 1'b1;
        @(posedge clk);
        #1;
        n_chk++; if (bus.in_ready !== 1'b1) $display("FAIL bp_release_in_ready got %b want 1", bus.in_ready); else n_pass++;
        n_chk++; if (bus.out_valid !== 1'b0) $display("FAIL bp_release_out_valid got %b want 0", bus.out_valid); else n_pass++;
        n_chk++; if (bus.r !== held) $display("FAIL bp_release_r got %b want %b", bus.r, held); else n_pass++;
        @(posedge clk);
        #1 bus.in_valid = 1'b0;
        n_chk++; if (bus.busy !== 1'b1) $display("FAIL bp_second_busy got %b want 1", bus.busy); else n_pass++;
        seen = 0;
        for (int k = 0; k < 20 && !seen; k++) begin
            @(negedge clk);
            seen = bus.out_valid;
        end
        n_chk++; if (bus.r !== ror_ref(a2, 3) || !seen) $display("FAIL bp_second_r got %b want %b", bus.r, ror_ref(a2, 3)); else n_pass++;
    endtask

    task automatic test_reset_mid;
        int extra_valid;
        @(negedge clk);
        for (int w = 0; w < 20 && !bus.in_ready; w++) @(negedge clk);
        bus.in_valid = 1'b1;
        bus.a        = 7'b1011001;
        bus.n        = 3'd5;
        @(posedge clk);
        #1 bus.in_valid = 1'b0;
        repeat (2) @(posedge clk);
        #2 rst_n = 1'b0;
        #1;
        n_chk++; if (bus.r !== 7'd0) $display("FAIL midrst_r got %b want 0000000", bus.r); else n_pass++;
        n_chk++; if (bus.out_valid !== 1'b0) $display("FAIL midrst_out_valid got %b want 0", bus.out_valid); else n_pass++;
        n_chk++; if (bus.in_ready !== 1'b1) $display("FAIL midrst_in_ready got %b want 1", bus.in_ready); else n_pass++;
        @(negedge clk);
        rst_n = 1'b1;
        extra_valid = 0;
        repeat (10) begin
            @(negedge clk);
            if (bus.out_valid) extra_valid++;
        end
        n_chk++; if (extra_valid != 0) $display("FAIL midrst_no_result got %0d valid cycles want 0", extra_valid); else n_pass++;
    endtask

    task automatic test_inverse;
        logic [6:0] rv;
        int lat;
        for (int av = 0; av < 128; av++) begin
            for (int nv = 0; nv < 7; nv++) begin
                run_op(rol_ref(7'(av), nv), 3'(nv), rv, lat);
                n_chk++; if (rv !== 7'(av)) $display("FAIL inverse_r a=%0d n=%0d got %b want %b", av, nv, rv, 7'(av)); else n_pass++;
                n_chk++; if (lat != nv + 1) $display("FAIL inverse_latency n=%0d got %0d want %0d", nv, lat, nv + 1); else n_pass++;
            end
        end
    endtask

    initial begin
        n_pass = 0;
        n_chk  = 0;
        test_reset();
        test_single_bit();
        test_known();
        test_amount_edges();
        test_random();
        test_backpressure();
        test_reset_mid();
        test_inverse();
        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
